// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter
//   Owns a 64-bit XNOR LFSR (taps 63,62,60,59, shifting left with the feedback
//   entering bit 0) and shares it round-robin among NREQ requesters using a
//   req/gnt/ack handshake. Each grant advances the LFSR STEPS times and then
//   delivers the new value. A seed can be loaded while idle. After reset or a
//   seed load, the LFSR runs WARMUP shifts before it serves any requester.
//
// Ports
//   clk        : clock, all state changes on posedge
//   reset      : asynchronous, active-low reset
//   seed_load  : load seed (honoured only while idle)
//   seed       : seed value; all-ones is replaced by DEFAULT_SEED
//   req        : level request per requester, held until ack
//   ack        : requester accepts the word; only the granted bit counts
//   gnt        : one-hot grant (registered)
//   rand_valid : rand_data is valid for the granted requester
//   rand_data  : delivered word; keeps the last delivered value
//   busy       : high in every state except idle
//   seed_err   : one-cycle pulse when an all-ones seed was replaced
module lfsr_rand_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          STEPS        = 1,
  parameter int          WARMUP       = 16,
  parameter logic [63:0] DEFAULT_SEED = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [63:0]     seed,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] gnt,
  output logic            rand_valid,
  output logic [63:0]     rand_data,
  output logic            busy,
  output logic            seed_err
);

  localparam int          IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [63:0] LOCKUP = '1;

  typedef enum logic [1:0] {WARM, IDLE, STEP, DELIVER} state_t;

  state_t          state;
  logic [63:0]     lfsr;
  logic [63:0]     lfsr_next;
  logic [31:0]     warm_cnt;
  logic [31:0]     step_cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   granted;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic            found;
  int              idx;

  // The chained XNOR of four taps reduces to the inverted XOR of those taps,
  // which is why an all-zero state is legal and all-ones is the lock-up state.
  always_comb begin
    lfsr_next = {lfsr[62:0], ~(lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59])};
  end

  // Round-robin pick: first set request at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // The pointer moves past whoever was just served, whether they acked or aborted.
  assign next_ptr = (granted == IW'(NREQ - 1)) ? '0 : granted + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WARM;
      lfsr       <= DEFAULT_SEED;
      warm_cnt   <= 32'(WARMUP);
      step_cnt   <= '0;
      rr_ptr     <= '0;
      granted    <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_data  <= '0;
      seed_err   <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      case (state)
        WARM: begin
          if (warm_cnt == 32'd0) begin
            state <= IDLE;
          end else begin
            lfsr     <= lfsr_next;
            warm_cnt <= warm_cnt - 32'd1;
          end
        end

        IDLE: begin
          // Seed loading takes priority over serving requests.
          if (seed_load) begin
            if (seed == LOCKUP) begin
              lfsr     <= DEFAULT_SEED;
              seed_err <= 1'b1;
            end else begin
              lfsr <= seed;
            end
            warm_cnt <= 32'(WARMUP);
            state    <= WARM;
          end else if (|req) begin
            gnt      <= NREQ'(1) << pick;
            granted  <= pick;
            step_cnt <= 32'(STEPS);
            state    <= STEP;
          end
        end

        STEP: begin
          // A requester dropping its request abandons the grant; the shifts
          // already taken stay in the LFSR.
          if (!req[granted]) begin
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            lfsr     <= lfsr_next;
            step_cnt <= step_cnt - 32'd1;
            if (step_cnt == 32'd1) begin
              rand_data  <= lfsr_next;
              rand_valid <= 1'b1;
              state      <= DELIVER;
            end
          end
        end

        DELIVER: begin
          if (!req[granted] || ack[granted]) begin
            gnt        <= '0;
            rand_valid <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter
//   Two instances: dut_a (STEPS=1, WARMUP=0) runs a table of per-cycle vectors
//   covering sequential words, round-robin order, seed handling and ignored
//   acks/seed loads; dut_b (STEPS=4, WARMUP=2) runs hand-written sequences for
//   warm-up length, aborted grants and asynchronous reset during delivery.
module tb_lfsr_rand_arbiter;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        sl;
    logic [63:0] seed;
    logic [3:0]  egnt;
    logic        evalid;
    logic [63:0] edata;
    logic        ebusy;
    logic        eserr;
  } vec_t;

  logic        clk;
  logic        reset_a, reset_b;
  logic        seed_load_a, seed_load_b;
  logic [63:0] seed_a, seed_b;
  logic [3:0]  req_a, req_b, ack_a, ack_b;
  logic [3:0]  gnt_a, gnt_b;
  logic        valid_a, valid_b;
  logic [63:0] data_a, data_b;
  logic        busy_a, busy_b;
  logic        serr_a, serr_b;

  int   total;
  int   bad;
  vec_t vecs[$];

  lfsr_rand_arbiter #(.NREQ(4), .STEPS(1), .WARMUP(0), .DEFAULT_SEED(64'h0)) dut_a (
    .clk(clk), .reset(reset_a), .seed_load(seed_load_a), .seed(seed_a),
    .req(req_a), .ack(ack_a), .gnt(gnt_a), .rand_valid(valid_a),
    .rand_data(data_a), .busy(busy_a), .seed_err(serr_a)
  );

  lfsr_rand_arbiter #(.NREQ(4), .STEPS(4), .WARMUP(2), .DEFAULT_SEED(64'h0)) dut_b (
    .clk(clk), .reset(reset_b), .seed_load(seed_load_b), .seed(seed_b),
    .req(req_b), .ack(ack_b), .gnt(gnt_b), .rand_valid(valid_b),
    .rand_data(data_b), .busy(busy_b), .seed_err(serr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addRow(input logic [3:0] r, input logic [3:0] a, input logic sl,
                        input logic [63:0] sd, input logic [3:0] g, input logic v,
                        input logic [63:0] d, input logic b, input logic se);
    vec_t x;
    x.req = r; x.ack = a; x.sl = sl; x.seed = sd;
    x.egnt = g; x.evalid = v; x.edata = d; x.ebusy = b; x.eserr = se;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t v);
    req_a       = v.req;
    ack_a       = v.ack;
    seed_load_a = v.sl;
    seed_a      = v.seed;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_a = 1'b0; reset_b = 1'b0;
    seed_load_a = 1'b0; seed_load_b = 1'b0;
    seed_a = '0; seed_b = '0;
    req_a = '0; req_b = '0; ack_a = '0; ack_b = '0;

    //      req    ack    sl  seed           gnt    v  data       busy serr
    addRow(4'h0, 4'h0, 0, 64'h0,         4'h0, 0, 64'h0,    0, 0); // 0 warm -> idle
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 0, 64'h0,    1, 0); // 1
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 1, 64'h1,    1, 0); // 2 first word
    addRow(4'h1, 4'h1, 0, 64'h0,         4'h0, 0, 64'h1,    0, 0); // 3 ack
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 0, 64'h1,    1, 0); // 4
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 1, 64'h3,    1, 0); // 5
    addRow(4'h1, 4'h4, 0, 64'h0,         4'h1, 1, 64'h3,    1, 0); // 6 foreign ack ignored
    addRow(4'h1, 4'h1, 0, 64'h0,         4'h0, 0, 64'h3,    0, 0); // 7
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 0, 64'h3,    1, 0); // 8
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 1, 64'h7,    1, 0); // 9
    addRow(4'h1, 4'h1, 0, 64'h0,         4'h0, 0, 64'h7,    0, 0); // 10 rr_ptr=1
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h2, 0, 64'h7,    1, 0); // 11 round robin
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h2, 1, 64'hF,    1, 0); // 12
    addRow(4'hF, 4'h2, 0, 64'h0,         4'h0, 0, 64'hF,    0, 0); // 13
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h4, 0, 64'hF,    1, 0); // 14
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h4, 1, 64'h1F,   1, 0); // 15
    addRow(4'hF, 4'h4, 0, 64'h0,         4'h0, 0, 64'h1F,   0, 0); // 16
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h8, 0, 64'h1F,   1, 0); // 17
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h8, 1, 64'h3F,   1, 0); // 18
    addRow(4'hF, 4'h8, 0, 64'h0,         4'h0, 0, 64'h3F,   0, 0); // 19 wrap to 0
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h1, 0, 64'h3F,   1, 0); // 20
    addRow(4'hF, 4'h0, 0, 64'h0,         4'h1, 1, 64'h7F,   1, 0); // 21
    addRow(4'hF, 4'h1, 0, 64'h0,         4'h0, 0, 64'h7F,   0, 0); // 22
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 0, 64'h7F,   1, 0); // 23
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 1, 64'hFF,   1, 0); // 24
    addRow(4'h1, 4'h0, 1, 64'h1234,      4'h1, 1, 64'hFF,   1, 0); // 25 seed in DELIVER ignored
    addRow(4'h1, 4'h1, 0, 64'h0,         4'h0, 0, 64'hFF,   0, 0); // 26
    addRow(4'h2, 4'h0, 1, 64'h5,         4'h0, 0, 64'hFF,   1, 0); // 27 seed beats req
    addRow(4'h0, 4'h0, 0, 64'h0,         4'h0, 0, 64'hFF,   0, 0); // 28 busy one cycle
    addRow(4'h2, 4'h0, 0, 64'h0,         4'h2, 0, 64'hFF,   1, 0); // 29
    addRow(4'h2, 4'h0, 0, 64'h0,         4'h2, 1, 64'hB,    1, 0); // 30 step from seed 5
    addRow(4'h2, 4'h2, 0, 64'h0,         4'h0, 0, 64'hB,    0, 0); // 31
    addRow(4'h0, 4'h0, 1, '1,            4'h0, 0, 64'hB,    1, 1); // 32 illegal seed
    addRow(4'h0, 4'h0, 0, 64'h0,         4'h0, 0, 64'hB,    0, 0); // 33 pulse ends
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 0, 64'hB,    1, 0); // 34
    addRow(4'h1, 4'h0, 0, 64'h0,         4'h1, 1, 64'h1,    1, 0); // 35 default sequence
    addRow(4'h1, 4'h1, 0, 64'h0,         4'h0, 0, 64'h1,    0, 0); // 36

    // Reset values while reset is held low.
    #12;
    checkOutput("a reset gnt",   64'(gnt_a),   64'h0);
    checkOutput("a reset valid", 64'(valid_a), 64'h0);
    checkOutput("a reset data",  data_a,       64'h0);
    checkOutput("a reset busy",  64'(busy_a),  64'h1);
    checkOutput("a reset serr",  64'(serr_a),  64'h0);
    checkOutput("b reset busy",  64'(busy_b),  64'h1);

    @(negedge clk);
    reset_a = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d gnt", i),   64'(gnt_a),   64'(vecs[i].egnt));
      checkOutput($sformatf("row%0d valid", i), 64'(valid_a), 64'(vecs[i].evalid));
      checkOutput($sformatf("row%0d data", i),  data_a,       vecs[i].edata);
      checkOutput($sformatf("row%0d busy", i),  64'(busy_a),  64'(vecs[i].ebusy));
      checkOutput($sformatf("row%0d serr", i),  64'(serr_a),  64'(vecs[i].eserr));
      @(negedge clk);
    end
    applyStimulus('{default: '0});

    // dut_b: warm-up keeps busy high for WARMUP+1 cycles after reset release.
    reset_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b warm busy %0d", k), 64'(busy_b), (k < 2) ? 64'h1 : 64'h0);
      checkOutput($sformatf("b warm gnt %0d", k),  64'(gnt_b),  64'h0);
      @(negedge clk);
    end

    // Grant to requester 1, drop its request on the second STEP cycle.
    req_b = 4'b0010;
    @(posedge clk); #1;
    checkOutput("b grant1", 64'(gnt_b), 64'h2);
    @(negedge clk);
    @(posedge clk); #1;
    checkOutput("b step1 gnt",   64'(gnt_b),   64'h2);
    checkOutput("b step1 valid", 64'(valid_b), 64'h0);
    @(negedge clk);
    req_b = 4'b0000;
    @(posedge clk); #1;
    checkOutput("b abort gnt",   64'(gnt_b),   64'h0);
    checkOutput("b abort valid", 64'(valid_b), 64'h0);
    checkOutput("b abort busy",  64'(busy_b),  64'h0);
    checkOutput("b abort data",  data_b,       64'h0);
    @(negedge clk);

    // Pointer moved past requester 1, so requester 2 wins next.
    req_b = 4'b1111;
    @(posedge clk); #1;
    checkOutput("b grant2", 64'(gnt_b), 64'h4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
      checkOutput($sformatf("b latency valid %0d", k), 64'(valid_b), (k == 4) ? 64'h1 : 64'h0);
    end
    // 0x3 after warm-up, 0x7 before the abort, then four more shifts.
    checkOutput("b deliver data", data_b, 64'h7F);
    checkOutput("b deliver gnt",  64'(gnt_b), 64'h4);

    // Asynchronous reset in the middle of DELIVER.
    @(negedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    checkOutput("b async gnt",   64'(gnt_b),   64'h0);
    checkOutput("b async valid", 64'(valid_b), 64'h0);
    checkOutput("b async data",  data_b,       64'h0);
    checkOutput("b async busy",  64'(busy_b),  64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends even if the flow above stalls.
  initial begin
    #20000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
